// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: bus widths, reset PC and fetch FSM encodings.
package if_fetch_stage_pkg;

   localparam int unsigned ID_TO_IF_BUS_WD  = 33;
   localparam int unsigned IF_TO_IPD_BUS_WD = 64;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

   typedef enum logic [1:0] {
      FS_REQ     = 2'd0,
      FS_WAIT    = 2'd1,
      FS_DISCARD = 2'd2
   } fetch_state_e;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & 32'hffff_fffc;
   endfunction

endpackage

// File: rtl/if_inst_slot.sv
// One-entry instruction buffer between fetch and IPD; flush beats load beats drain.
module if_inst_slot
   import if_fetch_stage_pkg::*;
#(
   parameter int unsigned WIDTH = IF_TO_IPD_BUS_WD
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             drain,
   input  logic             flush,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         // A simultaneous drain is covered here: the new word replaces the leaving one.
         valid <= 1'b1;
         data  <= load_data;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the fetch PC, keeps one request outstanding and feeds the slot toward IPD.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned BUS_WD_ID  = ID_TO_IF_BUS_WD,
   parameter int unsigned BUS_WD_IPD = IF_TO_IPD_BUS_WD
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BUS_WD_ID-1:0]  ID_to_IF_bus,
   input  logic                  IPD_allow_in,
   output logic                  IF_to_IPD_valid,
   output logic [BUS_WD_IPD-1:0] IF_to_IPD_bus,
   output logic                  inst_req,
   output logic [31:0]           inst_addr,
   input  logic                  inst_addr_ok,
   input  logic                  inst_data_ok,
   input  logic [31:0]           inst_rdata
);

   fetch_state_e state;
   logic [31:0]  fetch_pc;
   logic [31:0]  req_pc;
   logic         br_taken_cancel;
   logic [31:0]  pc_from_id;
   logic         slot_valid;
   logic         slot_load;
   logic         drain;
   logic         accept;

   assign br_taken_cancel = ID_to_IF_bus[32];
   assign pc_from_id      = ID_to_IF_bus[31:0];

   assign inst_addr = align_word(fetch_pc);
   assign inst_req  = ~reset & (state == FS_REQ) & (~slot_valid | IPD_allow_in);
   assign accept    = inst_req & inst_addr_ok;
   assign drain     = slot_valid & IPD_allow_in;
   assign slot_load = (state == FS_WAIT) & inst_data_ok & ~br_taken_cancel;

   assign IF_to_IPD_valid = slot_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         state    <= FS_REQ;
      end else if (br_taken_cancel) begin
         fetch_pc <= pc_from_id;
         unique case (state)
            FS_REQ:     state <= accept ? FS_DISCARD : FS_REQ;
            FS_WAIT:    state <= inst_data_ok ? FS_REQ : FS_DISCARD;
            FS_DISCARD: state <= inst_data_ok ? FS_REQ : FS_DISCARD;
            default:    state <= FS_REQ;
         endcase
      end else begin
         unique case (state)
            FS_REQ: begin
               // A data_ok seen here belongs to a request abandoned by reset.
               if (accept) begin
                  req_pc   <= inst_addr;
                  fetch_pc <= fetch_pc + 32'd4;
                  state    <= FS_WAIT;
               end
            end
            FS_WAIT:    if (inst_data_ok) state <= FS_REQ;
            FS_DISCARD: if (inst_data_ok) state <= FS_REQ;
            default:    state <= FS_REQ;
         endcase
      end
   end

   if_inst_slot #(
      .WIDTH(BUS_WD_IPD)
   ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .load     (slot_load),
      .load_data({req_pc, inst_rdata}),
      .drain    (drain),
      .flush    (br_taken_cancel),
      .valid    (slot_valid),
      .data     (IF_to_IPD_bus)
   );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: fetch, stall, redirects, PC wrap and mid-transaction reset.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [32:0] ID_to_IF_bus;
   logic        IPD_allow_in;
   logic        IF_to_IPD_valid;
   logic [63:0] IF_to_IPD_bus;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   if_fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .ID_to_IF_bus   (ID_to_IF_bus),
      .IPD_allow_in   (IPD_allow_in),
      .IF_to_IPD_valid(IF_to_IPD_valid),
      .IF_to_IPD_bus  (IF_to_IPD_bus),
      .inst_req       (inst_req),
      .inst_addr      (inst_addr),
      .inst_addr_ok   (inst_addr_ok),
      .inst_data_ok   (inst_data_ok),
      .inst_rdata     (inst_rdata)
   );

   function automatic logic [31:0] word_of(input logic [31:0] addr);
      return addr ^ 32'h1357_9bdf;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request at exp_addr, answer after k cycles, and check the slot contents.
   task automatic fetch_one(input logic [31:0] exp_addr, input int k);
      inst_addr_ok = 1'b1;
      #1;
      chk("fetch_req", {63'd0, inst_req}, 64'd1);
      chk("fetch_addr", {32'd0, inst_addr}, {32'd0, exp_addr});
      tick();
      inst_addr_ok = 1'b0;
      for (int i = 1; i < k; i++) begin
         tick();
         chk("fetch_wait_valid", {63'd0, IF_to_IPD_valid}, 64'd0);
      end
      inst_data_ok = 1'b1;
      inst_rdata   = word_of(exp_addr);
      #1;
      chk("fetch_no_early_valid", {63'd0, IF_to_IPD_valid}, 64'd0);
      tick();
      inst_data_ok = 1'b0;
      inst_rdata   = 32'hdead_beef;
      chk("fetch_valid", {63'd0, IF_to_IPD_valid}, 64'd1);
      chk("fetch_bus", IF_to_IPD_bus, {exp_addr, word_of(exp_addr)});
   endtask

   initial begin
      reset        = 1'b1;
      ID_to_IF_bus = '0;
      IPD_allow_in = 1'b0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
      tick();
      tick();
      chk("rst_req", {63'd0, inst_req}, 64'd0);
      chk("rst_valid", {63'd0, IF_to_IPD_valid}, 64'd0);
      chk("rst_bus", IF_to_IPD_bus, 64'd0);
      reset = 1'b0;

      // First fetch with IPD stalled, then hold the full slot for 5 cycles.
      fetch_one(32'h1c00_0000, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_req", {63'd0, inst_req}, 64'd0);
         chk("stall_bus", IF_to_IPD_bus, {32'h1c00_0000, word_of(32'h1c00_0000)});
         chk("stall_addr", {32'd0, inst_addr}, 64'h1c00_0004);
      end
      IPD_allow_in = 1'b1;
      fetch_one(32'h1c00_0004, 1);

      // Request 1c000008, then cancel while waiting for it.
      inst_addr_ok = 1'b1;
      #1;
      chk("w_req", {32'd0, inst_addr}, 64'h1c00_0008);
      tick();
      inst_addr_ok = 1'b0;
      chk("w_drained", {63'd0, IF_to_IPD_valid}, 64'd0);
      ID_to_IF_bus = {1'b1, 32'h1c00_0100};
      tick();
      ID_to_IF_bus = '0;
      chk("discard_valid", {63'd0, IF_to_IPD_valid}, 64'd0);
      chk("discard_noreq", {63'd0, inst_req}, 64'd0);
      tick();
      chk("discard_hold", {63'd0, inst_req}, 64'd0);
      inst_data_ok = 1'b1;
      inst_rdata   = 32'h0bad_0bad;
      tick();
      inst_data_ok = 1'b0;
      chk("dropped_valid", {63'd0, IF_to_IPD_valid}, 64'd0);
      fetch_one(32'h1c00_0100, 1);

      // Cancel in REQ without addr_ok, then cancel coinciding with addr_ok.
      ID_to_IF_bus = {1'b1, 32'h1c00_0010};
      tick();
      chk("redir_flush", {63'd0, IF_to_IPD_valid}, 64'd0);
      chk("redir_addr", {32'd0, inst_addr}, 64'h1c00_0010);
      ID_to_IF_bus = {1'b1, 32'h1c00_0200};
      inst_addr_ok = 1'b1;
      #1;
      chk("same_req", {63'd0, inst_req}, 64'd1);
      chk("same_addr", {32'd0, inst_addr}, 64'h1c00_0010);
      tick();
      ID_to_IF_bus = '0;
      inst_addr_ok = 1'b0;
      chk("same_discard", {63'd0, inst_req}, 64'd0);
      inst_data_ok = 1'b1;
      inst_rdata   = 32'h0bad_0010;
      tick();
      inst_data_ok = 1'b0;
      chk("same_dropped", {63'd0, IF_to_IPD_valid}, 64'd0);
      fetch_one(32'h1c00_0200, 1);

      // addr_ok held low; cancel mid-way retargets the pending request.
      #1;
      chk("hold1_addr", {32'd0, inst_addr}, 64'h1c00_0204);
      tick();
      ID_to_IF_bus = {1'b1, 32'h1c00_0300};
      #1;
      chk("hold2_req", {63'd0, inst_req}, 64'd1);
      tick();
      ID_to_IF_bus = '0;
      chk("hold3_req", {63'd0, inst_req}, 64'd1);
      chk("hold3_addr", {32'd0, inst_addr}, 64'h1c00_0300);
      fetch_one(32'h1c00_0300, 1);

      // Misaligned redirect target reports the aligned address.
      ID_to_IF_bus = {1'b1, 32'h1c00_0402};
      tick();
      ID_to_IF_bus = '0;
      fetch_one(32'h1c00_0400, 2);

      // Wrap past the top of the address space.
      ID_to_IF_bus = {1'b1, 32'hffff_fffc};
      tick();
      ID_to_IF_bus = '0;
      fetch_one(32'hffff_fffc, 1);
      #1;
      chk("wrap_addr", {32'd0, inst_addr}, 64'd0);

      // Accept a request, then reset while waiting; stray data_ok must be ignored.
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0;
      reset = 1'b1;
      tick();
      chk("rst2_valid", {63'd0, IF_to_IPD_valid}, 64'd0);
      chk("rst2_bus", IF_to_IPD_bus, 64'd0);
      chk("rst2_req", {63'd0, inst_req}, 64'd0);
      reset        = 1'b0;
      inst_data_ok = 1'b1;
      inst_rdata   = 32'h0bad_ffff;
      #1;
      chk("stray_req", {63'd0, inst_req}, 64'd1);
      tick();
      inst_data_ok = 1'b0;
      chk("stray_valid", {63'd0, IF_to_IPD_valid}, 64'd0);
      chk("stray_addr", {32'd0, inst_addr}, 64'h1c00_0000);
      fetch_one(32'h1c00_0000, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
